// File: rtl/pc_redirect_unit_pkg.sv
// Shared definitions for the fetch PC redirect logic: pc_src encodings,
// FSM states and the default boot address.
package pc_redirect_unit_pkg;

    localparam logic [1:0] PC_BOOT = 2'b00;
    localparam logic [1:0] PC_EPC  = 2'b01;
    localparam logic [1:0] PC_TRAP = 2'b10;
    localparam logic [1:0] PC_NEXT = 2'b11;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } pc_state_t;

endpackage

// File: rtl/pc_redirect_unit_target_mux.sv
// Combinational next-fetch target select: boot > trap > epc > taken branch
// > sequential, with JALR bit-0 clearing and misaligned-target detection.
module pc_redirect_unit_target_mux
    import pc_redirect_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic [1:0]  pc_src_in,
    input  logic        branch_taken_in,
    input  logic [31:0] iadder_in,
    input  logic [31:0] epc_in,
    input  logic [31:0] trap_address_in,
    input  logic [31:0] i_addr_in,
    output logic [31:0] target_out,
    output logic        redirect_out,
    output logic        misaligned_out
);

    always_comb begin
        target_out     = i_addr_in + 32'd4;
        redirect_out   = 1'b1;
        misaligned_out = 1'b0;
        if (pc_src_in == PC_BOOT) begin
            target_out = RESET_PC;
        end else if (pc_src_in == PC_TRAP) begin
            target_out = trap_address_in;
        end else if (pc_src_in == PC_EPC) begin
            target_out = epc_in;
        end else if (branch_taken_in) begin
            // Bit 0 dropped per JALR; bit 1 set means a non-word target.
            target_out     = iadder_in & 32'hFFFF_FFFE;
            misaligned_out = iadder_in[1];
        end else begin
            redirect_out = 1'b0;
        end
    end

endmodule

// File: rtl/pc_redirect_unit.sv
// Fetch program counter owner: tracks fetch and execute PCs, applies
// redirects with a one-cycle flush and flags misaligned branch targets.
module pc_redirect_unit
    import pc_redirect_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        ahb_ready_in,
    input  logic        branch_taken_in,
    input  logic [31:0] iadder_in,
    input  logic [1:0]  pc_src_in,
    input  logic [31:0] epc_in,
    input  logic [31:0] trap_address_in,
    output logic [31:0] i_addr_out,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus_4_out,
    output logic        flush_out,
    output logic        misaligned_instr_out
);

    pc_state_t   state_q, state_d;
    logic [31:0] i_addr_q, i_addr_d;
    logic [31:0] pc_q, pc_d;
    logic        flush_q, flush_d;
    logic        misaligned_q, misaligned_d;

    logic [31:0] target;
    logic        redirect;
    logic        misaligned;
    logic        taken_eff;

    // The instruction in the flushed slot is dead, so its branch is ignored.
    assign taken_eff = branch_taken_in & ~flush_q;

    pc_redirect_unit_target_mux #(
        .RESET_PC (RESET_PC)
    ) u_target_mux (
        .pc_src_in       (pc_src_in),
        .branch_taken_in (taken_eff),
        .iadder_in       (iadder_in),
        .epc_in          (epc_in),
        .trap_address_in (trap_address_in),
        .i_addr_in       (i_addr_q),
        .target_out      (target),
        .redirect_out    (redirect),
        .misaligned_out  (misaligned)
    );

    always_comb begin
        state_d      = state_q;
        i_addr_d     = i_addr_q;
        pc_d         = pc_q;
        flush_d      = flush_q;
        misaligned_d = misaligned_q;
        if (ahb_ready_in) begin
            if (state_q == ST_BOOT) begin
                state_d      = ST_RUN;
                i_addr_d     = RESET_PC + 32'd4;
                pc_d         = RESET_PC;
                flush_d      = 1'b1;
                misaligned_d = 1'b0;
            end else begin
                pc_d         = i_addr_q;
                flush_d      = redirect;
                misaligned_d = misaligned;
                // A misaligned target is never fetched; trap logic redirects next.
                if (!misaligned) begin
                    i_addr_d = target;
                end
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q      <= ST_BOOT;
            i_addr_q     <= RESET_PC;
            pc_q         <= RESET_PC;
            flush_q      <= 1'b1;
            misaligned_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            i_addr_q     <= i_addr_d;
            pc_q         <= pc_d;
            flush_q      <= flush_d;
            misaligned_q <= misaligned_d;
        end
    end

    assign i_addr_out           = i_addr_q;
    assign pc_out               = pc_q;
    assign pc_plus_4_out        = pc_q + 32'd4;
    assign flush_out            = flush_q;
    assign misaligned_instr_out = misaligned_q;

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Directed bench for pc_redirect_unit with a behavioural PC model checked
// every cycle, plus literal expectations at key points of the sequence.
module tb_pc_redirect_unit;

    logic        clk;
    logic        rst;
    logic        ready;
    logic        taken;
    logic [31:0] iadder;
    logic [1:0]  pc_src;
    logic [31:0] epc;
    logic [31:0] trap_addr;
    logic [31:0] i_addr;
    logic [31:0] pc;
    logic [31:0] pc_plus_4;
    logic        flush;
    logic        mis;

    int n_checks = 0;
    int n_fail   = 0;

    pc_redirect_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk_in               (clk),
        .rst_in               (rst),
        .ahb_ready_in         (ready),
        .branch_taken_in      (taken),
        .iadder_in            (iadder),
        .pc_src_in            (pc_src),
        .epc_in               (epc),
        .trap_address_in      (trap_addr),
        .i_addr_out           (i_addr),
        .pc_out               (pc),
        .pc_plus_4_out        (pc_plus_4),
        .flush_out            (flush),
        .misaligned_instr_out (mis)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model of the fetch/execute PCs.
    logic [31:0] m_iaddr, m_pc;
    logic        m_flush, m_mis, m_boot;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_iaddr = 32'h0; m_pc = 32'h0; m_flush = 1'b1; m_mis = 1'b0; m_boot = 1'b1;
        end else if (ready) begin
            if (m_boot) begin
                m_pc = 32'h0; m_iaddr = 32'h4; m_flush = 1'b1; m_mis = 1'b0; m_boot = 1'b0;
            end else begin
                logic        br;
                logic [31:0] old;
                br  = taken && !m_flush;
                old = m_iaddr;
                m_pc  = old;
                m_mis = 1'b0;
                m_flush = 1'b1;
                if (pc_src == 2'd0)      m_iaddr = 32'h0;
                else if (pc_src == 2'd2) m_iaddr = trap_addr;
                else if (pc_src == 2'd1) m_iaddr = epc;
                else if (br) begin
                    if (iadder[1]) m_mis = 1'b1;
                    else           m_iaddr = {iadder[31:1], 1'b0};
                end else begin
                    m_iaddr = old + 32'd4;
                    m_flush = 1'b0;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("model_i_addr", i_addr, m_iaddr);
        chk("model_pc", pc, m_pc);
        chk("model_pc_plus_4", pc_plus_4, m_pc + 32'd4);
        chk("model_flush", {31'b0, flush}, {31'b0, m_flush});
        chk("model_misaligned", {31'b0, mis}, {31'b0, m_mis});
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic set_in(input logic [1:0] src, input logic tk, input logic [31:0] ia);
        pc_src = src; taken = tk; iadder = ia;
    endtask

    initial begin
        rst = 1'b1; ready = 1'b1; taken = 1'b0; iadder = 32'h0;
        pc_src = 2'b11; epc = 32'h0; trap_addr = 32'h0;
        step(); step();
        chk("reset_i_addr", i_addr, 32'h0);
        chk("reset_flush", {31'b0, flush}, 32'h1);
        chk("reset_mis", {31'b0, mis}, 32'h0);
        rst = 1'b0;
        step();
        chk("boot_i_addr", i_addr, 32'h4);
        chk("boot_pc", pc, 32'h0);
        chk("boot_flush", {31'b0, flush}, 32'h1);
        step();
        chk("seq1_i_addr", i_addr, 32'h8);
        chk("seq1_flush", {31'b0, flush}, 32'h0);
        step();
        chk("seq2_i_addr", i_addr, 32'hC);
        repeat (13) step();
        chk("pre_reset_i_addr", i_addr, 32'h40);
        // Asynchronous reset mid-stream.
        rst = 1'b1;
        #1;
        chk("async_rst_i_addr", i_addr, 32'h0);
        chk("async_rst_pc", pc, 32'h0);
        chk("async_rst_flush", {31'b0, flush}, 32'h1);
        step();
        rst = 1'b0;
        step();
        chk("reboot_i_addr", i_addr, 32'h4);
        step();
        // Taken branch from 0x100, then branch in flushed slot ignored.
        trap_addr = 32'hFC; set_in(2'b10, 1'b0, 32'h0);
        step();
        set_in(2'b11, 1'b0, 32'h0);
        step();
        chk("pre_branch_i_addr", i_addr, 32'h100);
        set_in(2'b11, 1'b1, 32'h80);
        step();
        chk("branch_i_addr", i_addr, 32'h80);
        chk("branch_pc", pc, 32'h100);
        chk("branch_flush", {31'b0, flush}, 32'h1);
        step();
        chk("flushed_slot_i_addr", i_addr, 32'h84);
        chk("flushed_slot_flush", {31'b0, flush}, 32'h0);
        // JALR bit-0 clear and misalignment.
        set_in(2'b11, 1'b1, 32'h201);
        step();
        chk("jalr_i_addr", i_addr, 32'h200);
        chk("jalr_mis", {31'b0, mis}, 32'h0);
        set_in(2'b11, 1'b0, 32'h0);
        step();
        set_in(2'b11, 1'b1, 32'h202);
        step();
        chk("mis_flag", {31'b0, mis}, 32'h1);
        chk("mis_i_addr_hold", i_addr, 32'h204);
        chk("mis_flush", {31'b0, flush}, 32'h1);
        trap_addr = 32'h1C0; set_in(2'b10, 1'b1, 32'h80);
        step();
        chk("mis_trap_i_addr", i_addr, 32'h1C0);
        chk("mis_pulse_end", {31'b0, mis}, 32'h0);
        set_in(2'b11, 1'b0, 32'h0);
        step();
        // Trap beats a live taken branch.
        set_in(2'b10, 1'b1, 32'h80);
        step();
        chk("prio_trap_i_addr", i_addr, 32'h1C0);
        epc = 32'h104; set_in(2'b01, 1'b0, 32'h0);
        step();
        chk("epc_i_addr", i_addr, 32'h104);
        set_in(2'b00, 1'b1, 32'h80);
        step();
        chk("bootsrc_i_addr", i_addr, 32'h0);
        // Stall with a pending branch at i_addr 0x20.
        trap_addr = 32'h1C; set_in(2'b10, 1'b0, 32'h0);
        step();
        set_in(2'b11, 1'b0, 32'h0);
        step();
        chk("pre_stall_i_addr", i_addr, 32'h20);
        ready = 1'b0; set_in(2'b11, 1'b1, 32'h300);
        repeat (3) step();
        chk("stall_i_addr", i_addr, 32'h20);
        chk("stall_pc", pc, 32'h1C);
        chk("stall_flush", {31'b0, flush}, 32'h0);
        ready = 1'b1;
        step();
        chk("unstall_i_addr", i_addr, 32'h300);
        chk("unstall_pc", pc, 32'h20);
        // Reset during a stall.
        ready = 1'b0; rst = 1'b1;
        #1;
        chk("stall_rst_i_addr", i_addr, 32'h0);
        step();
        rst = 1'b0; ready = 1'b1; set_in(2'b11, 1'b0, 32'h0);
        step(); step();
        // Address wrap.
        trap_addr = 32'hFFFF_FFF8; set_in(2'b10, 1'b0, 32'h0);
        step();
        set_in(2'b11, 1'b0, 32'h0);
        step();
        chk("wrap_pre_i_addr", i_addr, 32'hFFFF_FFFC);
        step();
        chk("wrap_i_addr", i_addr, 32'h0);
        chk("wrap_pc", pc, 32'hFFFF_FFFC);
        chk("wrap_pc_plus_4", pc_plus_4, 32'h0);
        step();
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
